// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM compare/output stage.
package pwm_pkg;

    localparam int unsigned PWM_N_DEFAULT      = 64;
    localparam int unsigned PWM_DEAD_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HI_ON   = 3'd1,
        DEAD_HL = 3'd2,
        LO_ON   = 3'd3,
        DEAD_LH = 3'd4
    } pwm_state_e;

    // Level an output rests at when not driving, for a given polarity.
    function automatic logic inactive_level(input logic active_high);
        return ~active_high;
    endfunction

endpackage

// File: rtl/pwm_compare_output_if.sv
// Timer/bus-side signal bundle of the PWM compare/output stage.
interface pwm_compare_output_if
    import pwm_pkg::*;
#(
    parameter int unsigned N      = PWM_N_DEFAULT,
    parameter int unsigned DEAD_W = PWM_DEAD_W_DEFAULT
);
    logic [N-1:0]      count;
    logic [N-1:0]      period;
    logic [N-1:0]      duty_in;
    logic              duty_load;
    logic              enable;
    logic [DEAD_W-1:0] deadtime;
    logic              pwm_hi;
    logic              pwm_lo;
    logic              period_end;
    logic [N-1:0]      duty_active;

    modport master (
        output count, period, duty_in, duty_load, enable, deadtime,
        input  pwm_hi, pwm_lo, period_end, duty_active
    );

    modport slave (
        input  count, period, duty_in, duty_load, enable, deadtime,
        output pwm_hi, pwm_lo, period_end, duty_active
    );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary output FSM with dead-time insertion; built only with PWM_DEADTIME_EN.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD_W      = PWM_DEAD_W_DEFAULT,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dmd,
    input  logic              enable,
    input  logic [DEAD_W-1:0] deadtime,
    output logic              pwm_hi,
    output logic              pwm_lo
);
    localparam logic INACTIVE = inactive_level(ACTIVE_HIGH);

    pwm_state_e        state, next_state;
    logic [DEAD_W-1:0] dead_cnt, next_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dead_cnt <= '0;
            pwm_hi   <= INACTIVE;
            pwm_lo   <= INACTIVE;
        end else begin
            state    <= next_state;
            dead_cnt <= next_cnt;
            // Outputs follow the next state so a transition costs one clock.
            pwm_hi   <= (next_state == HI_ON) ^ INACTIVE;
            pwm_lo   <= (next_state == LO_ON) ^ INACTIVE;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = dead_cnt;
        if (!enable) begin
            next_state = IDLE;
            next_cnt   = '0;
        end else begin
            unique case (state)
                IDLE: next_state = dmd ? HI_ON : LO_ON;
                HI_ON: begin
                    if (!dmd) begin
                        if (deadtime == '0) begin
                            next_state = LO_ON;
                        end else begin
                            next_state = DEAD_HL;
                            next_cnt   = deadtime - DEAD_W'(1);
                        end
                    end
                end
                LO_ON: begin
                    if (dmd) begin
                        if (deadtime == '0) begin
                            next_state = HI_ON;
                        end else begin
                            next_state = DEAD_LH;
                            next_cnt   = deadtime - DEAD_W'(1);
                        end
                    end
                end
                DEAD_HL, DEAD_LH: begin
                    // Exit on the live demand so short pulses are absorbed.
                    if (dead_cnt == '0) begin
                        next_state = dmd ? HI_ON : LO_ON;
                    end else begin
                        next_cnt = dead_cnt - DEAD_W'(1);
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_compare_output.sv
// PWM compare/output stage: double-buffered duty, period-end pulse, complementary drive.
// Define PWM_DEADTIME_EN to build the dead-time FSM; otherwise outputs follow demand directly.
module pwm_compare_output
    import pwm_pkg::*;
#(
    parameter int unsigned N           = PWM_N_DEFAULT,
    parameter int unsigned DEAD_W      = PWM_DEAD_W_DEFAULT,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    pwm_compare_output_if.slave   bus
);
    localparam logic INACTIVE = inactive_level(ACTIVE_HIGH);

    logic [N-1:0] pending;
    logic [N-1:0] duty_active;
    logic         period_end;
    logic         wrap;
    logic         dmd;
    logic         pwm_hi;
    logic         pwm_lo;

    assign wrap = (bus.count >= bus.period);
    assign dmd  = (bus.count < duty_active);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            duty_active <= '0;
            period_end  <= 1'b0;
        end else begin
            period_end <= wrap;
            if (bus.duty_load) begin
                pending <= bus.duty_in;
            end
            // A load on the wrap cycle goes straight through to the shadow.
            if (wrap) begin
                duty_active <= bus.duty_load ? bus.duty_in : pending;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadtime_gen #(
        .DEAD_W      (DEAD_W),
        .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_deadtime_gen (
        .clock    (clock),
        .reset    (reset),
        .dmd      (dmd),
        .enable   (bus.enable),
        .deadtime (bus.deadtime),
        .pwm_hi   (pwm_hi),
        .pwm_lo   (pwm_lo)
    );
`else
    logic unused_deadtime;
    assign unused_deadtime = ^bus.deadtime;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_hi <= INACTIVE;
            pwm_lo <= INACTIVE;
        end else begin
            pwm_hi <= (dmd & bus.enable) ^ INACTIVE;
            pwm_lo <= (~dmd & bus.enable) ^ INACTIVE;
        end
    end
`endif

    assign bus.pwm_hi      = pwm_hi;
    assign bus.pwm_lo      = pwm_lo;
    assign bus.period_end  = period_end;
    assign bus.duty_active = duty_active;

endmodule

// File: tb/tb_pwm_compare_output.sv
// Directed self-checking bench for pwm_compare_output (default build and PWM_DEADTIME_EN build).
`timescale 1ns/1ps
module tb_pwm_compare_output;
    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    pwm_compare_output_if #(.N(64), .DEAD_W(8)) bus ();

    pwm_compare_output #(
        .N           (64),
        .DEAD_W      (8),
        .ACTIVE_HIGH (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic tick(input int c, input logic ld, input logic [63:0] din);
        bus.count     = 64'(c);
        bus.duty_load = ld;
        bus.duty_in   = din;
        @(posedge clock);
        #1;
        bus.duty_load = 1'b0;
    endtask

    task automatic check_pair(input string tag, input logic eh, input logic el);
        check({tag, "_hi"}, {63'd0, bus.pwm_hi}, {63'd0, eh});
        check({tag, "_lo"}, {63'd0, bus.pwm_lo}, {63'd0, el});
        check({tag, "_ovl"}, {63'd0, bus.pwm_hi & bus.pwm_lo}, 64'd0);
    endtask

    // One full count sweep 0..per; hi expected on counts h0..h1, lo on l0..l1.
    task automatic run_period(input int per, input bit chk, input int h0, input int h1,
                              input int l0, input int l1, input logic ld_last,
                              input logic [63:0] din_last);
        for (int c = 0; c <= per; c++) begin
            tick(c, ld_last && (c == per), din_last);
            if (chk) begin
                check_pair($sformatf("p%0d_c%0d", per, c), (c >= h0) && (c <= h1),
                           (c >= l0) && (c <= l1));
                check($sformatf("pe_c%0d", c), {63'd0, bus.period_end}, {63'd0, c == per});
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.count     = '0;
        bus.period    = 64'd9;
        bus.duty_in   = '0;
        bus.duty_load = 1'b0;
        bus.enable    = 1'b0;
        bus.deadtime  = '0;
        repeat (2) @(posedge clock);
        #1;
        check_pair("rst", 1'b0, 1'b0);
        check("rst_pe", {63'd0, bus.period_end}, 64'd0);
        check("rst_duty", bus.duty_active, 64'd0);

        reset = 1'b0;
        tick(0, 1'b0, 64'd0);
        check_pair("dis", 1'b0, 1'b0);
        bus.enable = 1'b1;

        // duty 0: low side only
        run_period(9, 1'b1, 1, 0, 0, 9, 1'b0, 64'd0);

        // load 4 mid-period; shadow waits for the wrap
        for (int c = 0; c <= 9; c++) begin
            tick(c, c == 2, 64'd4);
            if (c == 8) check("shadow_hold", bus.duty_active, 64'd0);
            if (c == 9) check("shadow_xfer", bus.duty_active, 64'd4);
        end

        // duty 4, with write-through load of 7 on the wrap cycle
        run_period(9, 1'b1, 0, 3, 4, 9, 1'b1, 64'd7);
        check("wthru", bus.duty_active, 64'd7);
        run_period(9, 1'b1, 0, 6, 7, 9, 1'b0, 64'd0);

        // reset mid-period
        for (int c = 0; c <= 3; c++) tick(c, 1'b0, 64'd0);
        check_pair("pre_rst", 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_pair("async_rst", 1'b0, 1'b0);
        check("async_rst_duty", bus.duty_active, 64'd0);
        @(posedge clock);
        #1;
        check("rst_hold_pe", {63'd0, bus.period_end}, 64'd0);
        reset = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            tick(c, c == 6, 64'd5);
            check_pair($sformatf("post_rst_c%0d", c), 1'b0, 1'b1);
            if (c == 8) check("post_rst_hold", bus.duty_active, 64'd0);
        end
        check("post_rst_xfer", bus.duty_active, 64'd5);

        // extremes at period 19
        bus.period   = 64'd19;
        bus.deadtime = 8'd3;
        run_period(19, 1'b0, 0, 0, 0, 0, 1'b1, 64'd25);
        check("duty25", bus.duty_active, 64'd25);
        run_period(19, 1'b0, 0, 0, 0, 0, 1'b0, 64'd0);
        run_period(19, 1'b1, 0, 19, 1, 0, 1'b1, 64'd0);
        run_period(19, 1'b0, 0, 0, 0, 0, 1'b0, 64'd0);
        run_period(19, 1'b1, 1, 0, 0, 19, 1'b1, 64'd10);
        run_period(19, 1'b0, 0, 0, 0, 0, 1'b0, 64'd0);

`ifdef PWM_DEADTIME_EN
        // duty 10, dead time 3 on both edges
        run_period(19, 1'b1, 3, 9, 13, 19, 1'b0, 64'd0);

        // drop enable inside the high-to-low dead window
        for (int c = 0; c <= 9; c++) tick(c, 1'b0, 64'd0);
        check_pair("dead_hi_end", 1'b1, 1'b0);
        tick(10, 1'b0, 64'd0);
        check_pair("dead_hl", 1'b0, 1'b0);
        bus.enable = 1'b0;
        tick(11, 1'b0, 64'd0);
        check_pair("dead_dis", 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick(12, 1'b0, 64'd0);
        check_pair("idle_reen", 1'b0, 1'b1);
        bus.deadtime = 8'd5;
        for (int c = 13; c <= 19; c++) tick(c, c == 19, 64'd2);

        // 2-cycle demand swallowed by 5 dead cycles
        run_period(19, 1'b1, 1, 0, 5, 19, 1'b0, 64'd0);
`else
        // dead time ignored
        run_period(19, 1'b1, 0, 9, 10, 19, 1'b0, 64'd0);
        for (int c = 0; c <= 4; c++) tick(c, 1'b0, 64'd0);
        bus.enable = 1'b0;
        tick(5, 1'b0, 64'd0);
        check_pair("dis_mid", 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick(6, 1'b0, 64'd0);
        check_pair("reen", 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
